// File: rtl/conv_ctrl_pkg.sv
// Shared FSM encodings, default kernel geometry and width helper for the weight sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_W = 3'd1,
    FETCH_B = 3'd2,
    CAPTURE = 3'd3,
    PRESENT = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int unsigned DEF_KSIZE = 3;
  localparam int unsigned DEF_KK    = DEF_KSIZE * DEF_KSIZE;

  // Ceiling log2, never below 1 so single-entry counters still get a real bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/kernel_shadow_reg.sv
// Shadow bank holding one filter's weights and its bias for presentation to the MAC array.
module kernel_shadow_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned KK     = 9,
  parameter int unsigned IW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_we,
  input  logic [IW-1:0]        w_idx,
  input  logic [DATA_W-1:0]    w_data,
  input  logic                 b_we,
  input  logic [BIAS_W-1:0]    b_data,
  output logic [KK*DATA_W-1:0] kernel,
  output logic [BIAS_W-1:0]    bias
);

  // Indexed weight slot write; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel <= '0;
    end else if (w_we) begin
      kernel[w_idx*DATA_W +: DATA_W] <= w_data;
    end
  end

  // Bias word write; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias <= '0;
    end else if (b_we) begin
      bias <= b_data;
    end
  end

endmodule

// File: rtl/conv_weight_sequencer.sv
// Fetches each filter's weights and bias from the weight memory, stages them in the
// shadow bank and presents them to the convolution engine over valid/ready.
module conv_weight_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BIAS_W      = 16,
  parameter int unsigned KSIZE       = DEF_KSIZE,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            mem_rd_en,
  output logic                            mem_sel_bias,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic                            kern_valid,
  input  logic                            kern_ready,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   kernel_out,
  output logic [BIAS_W-1:0]               bias_out,
  output logic [clog2(NUM_FILTERS)-1:0]   filter_idx,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned KK = KSIZE * KSIZE;
  localparam int unsigned FW = clog2(NUM_FILTERS);
  localparam int unsigned IW = clog2(KK);

  state_e            state, state_d;
  logic [FW-1:0]     f, f_d;
  logic [IW-1:0]     i, i_d;
  logic              rd_d, sel_d, valid_d, done_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic              w_we, b_we;
  logic [IW-1:0]     w_idx;
  logic [BIAS_W-1:0] bias_ext;

  assign bias_ext   = {{(BIAS_W-DATA_W){mem_rdata[DATA_W-1]}}, mem_rdata};
  assign filter_idx = f;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      f            <= '0;
      i            <= '0;
      mem_rd_en    <= 1'b0;
      mem_sel_bias <= 1'b0;
      mem_addr     <= '0;
      kern_valid   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      f            <= f_d;
      i            <= i_d;
      mem_rd_en    <= rd_d;
      mem_sel_bias <= sel_d;
      mem_addr     <= addr_d;
      kern_valid   <= valid_d;
      done         <= done_d;
      busy         <= busy_d;
    end
  end

  // Next state, capture strobes and next output values decoded from the next state.
  always_comb begin
    state_d = state;
    f_d     = f;
    i_d     = i;
    w_we    = 1'b0;
    w_idx   = i - IW'(1);
    b_we    = 1'b0;
    rd_d    = 1'b0;
    sel_d   = 1'b0;
    addr_d  = mem_addr;
    valid_d = 1'b0;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = FETCH_W;
          f_d     = '0;
          i_d     = '0;
        end
      end
      FETCH_W: begin
        w_we = (i != '0);
        if (i == IW'(KK-1)) state_d = FETCH_B;
        else                i_d     = i + IW'(1);
      end
      FETCH_B: begin
        w_we    = 1'b1;
        w_idx   = IW'(KK-1);
        state_d = CAPTURE;
      end
      CAPTURE: begin
        b_we    = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (kern_ready) begin
          if (f == FW'(NUM_FILTERS-1)) begin
            state_d = DONE;
          end else begin
            f_d     = f + FW'(1);
            i_d     = '0;
            state_d = FETCH_W;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    case (state_d)
      FETCH_W: begin
        rd_d   = 1'b1;
        addr_d = ADDR_W'(ADDR_W'(f_d) * ADDR_W'(KK) + ADDR_W'(i_d));
      end
      FETCH_B: begin
        rd_d   = 1'b1;
        sel_d  = 1'b1;
        addr_d = ADDR_W'(f_d);
      end
      PRESENT: valid_d = 1'b1;
      DONE:    done_d  = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  kernel_shadow_reg #(
    .DATA_W (DATA_W),
    .BIAS_W (BIAS_W),
    .KK     (KK),
    .IW     (IW)
  ) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_we   (w_we),
    .w_idx  (w_idx),
    .w_data (mem_rdata),
    .b_we   (b_we),
    .b_data (bias_ext),
    .kernel (kernel_out),
    .bias   (bias_out)
  );

endmodule
